// File: rtl/calc_entry_fsm_pkg.sv
// Shared types and constants for the calculator entry front end.
// Multiplier support is enabled in the top level by defining CALC_MUL_EN.
package calc_entry_fsm_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic signed [7:0] S8_MIN = -8'sd128;
  localparam logic signed [7:0] S8_MAX = 8'sd127;

  typedef enum logic [2:0] {
    S_A    = 3'b000,
    S_B    = 3'b001,
    S_EXEC = 3'b010,
    S_DONE = 3'b011,
    S_MUL  = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NEG = 2'b10,
    OP_MUL = 2'b11
  } op_t;

  // S_MUL is an internal refinement of execution and shows as the EXEC phase
  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] p;
    p = s[1:0];
    if (s == S_MUL) p = 2'b10;
    return p;
  endfunction

endpackage

// File: rtl/calc_entry_fsm_key_pulse.sv
// Key synchroniser with falling-edge one-shot: one press pulse per
// synchronised 1->0 transition of an active-low, asynchronous key.
module key_pulse #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Reset to the released level so deasserting reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign press = prev & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator entry FSM: captures A and B from switches on key presses,
// computes the selected operation and drives the display value x.
// Define CALC_MUL_EN to build the serial shift-add multiplier for op=11.
module calc_entry_fsm
  import calc_entry_fsm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       op,
  input  logic             key_n,
  output logic [WIDTH-1:0] x,
  output logic             ovf,
  output logic             err,
  output logic             busy,
  output logic [1:0]       phase
);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a, b;
  logic             press;

  logic [WIDTH-1:0] r_add, r_sub, r_neg;
  logic             ovf_add, ovf_sub, ovf_neg;

  key_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_key (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .press(press)
  );

  assign r_add   = a + b;
  assign r_sub   = a - b;
  assign r_neg   = '0 - a;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (r_add[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (r_sub[WIDTH-1] != a[WIDTH-1]);
  assign ovf_neg = a[WIDTH-1] && ~|a[WIDTH-2:0];

`ifdef CALC_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               mul_last, mul_ovf;

  assign mul_last = (cnt == CNT_W'(WIDTH - 1));

  // Two's-complement multiplier: the top multiplier bit carries negative weight
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = mul_last ? (acc - mcand) : (acc + mcand);
  end

  // Product fits in WIDTH signed bits only if its top WIDTH+1 bits agree
  assign mul_ovf = |acc_nxt[2*WIDTH-1:WIDTH-1] && ~&acc_nxt[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == S_EXEC) begin
      acc    <= '0;
      mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_A;
      op_q  <= OP_ADD;
      a     <= '0;
      b     <= '0;
      x     <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        S_A: begin
          x <= sw;
          if (press) begin
            a     <= sw;
            state <= S_B;
          end
        end
        S_B: begin
          x <= sw;
          if (press) begin
            b     <= sw;
            op_q  <= op_t'(op);
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          unique case (op_q)
            OP_ADD: begin x <= r_add; ovf <= ovf_add; end
            OP_SUB: begin x <= r_sub; ovf <= ovf_sub; end
            OP_NEG: begin x <= r_neg; ovf <= ovf_neg; end
            OP_MUL: begin
`ifdef CALC_MUL_EN
              state <= S_MUL;
`else
              x   <= '0;
              ovf <= 1'b0;
              err <= 1'b1;
`endif
            end
            default: state <= S_DONE;
          endcase
        end
`ifdef CALC_MUL_EN
        S_MUL: begin
          if (mul_last) begin
            x     <= acc_nxt[WIDTH-1:0];
            ovf   <= mul_ovf;
            state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (press) begin
            ovf   <= 1'b0;
            err   <= 1'b0;
            state <= S_A;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  assign busy  = (state == S_EXEC) || (state == S_MUL);
  assign phase = phase_of(state);

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Self-checking bench for calc_entry_fsm: table-driven operations plus
// hand sequences for key hold, bounce, busy drop and async reset.
module tb_calc_entry_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = '0;
  logic [1:0] op = '0;
  logic       key_n = 1'b1;
  logic [7:0] x;
  logic       ovf, err, busy;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  calc_entry_fsm #(.SYNC_STAGES(2), .WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .op   (op),
    .key_n(key_n),
    .x    (x),
    .ovf  (ovf),
    .err  (err),
    .busy (busy),
    .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] x;
    logic       ovf;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key();
    key_n = 1'b0;
    cycles(6);
    key_n = 1'b1;
    cycles(6);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(phase == 2'b11 && !busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    sw = v.a;
    op = 2'b00;
    press_key();
    sw = v.b;
    op = v.op;
    cycles(2);
    check($sformatf("echo_b[%0d]", idx), x, v.b);
    press_key();
    wait_done();
    check($sformatf("phase[%0d]", idx), phase, 2'b11);
    check($sformatf("x[%0d]", idx), x, v.x);
    check($sformatf("ovf[%0d]", idx), ovf, v.ovf);
    check($sformatf("err[%0d]", idx), err, v.err);
    press_key();
    check($sformatf("ret_phase[%0d]", idx), phase, 2'b00);
    check($sformatf("ret_flags[%0d]", idx), {ovf, err}, 2'b00);
    check($sformatf("ret_echo[%0d]", idx), x, v.b);
  endtask

  initial begin
    int changes;
    int nb;
    logic [1:0] prev_ph;

    vecs.push_back('{8'h05, 8'h03, 2'b00, 8'h08, 1'b0, 1'b0});
    vecs.push_back('{8'h64, 8'h64, 2'b00, 8'hC8, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h00, 2'b10, 8'h80, 1'b1, 1'b0});
    vecs.push_back('{8'h05, 8'h00, 2'b10, 8'hFB, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 2'b10, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'h03, 8'h05, 2'b01, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 2'b00, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 2'b00, 8'h80, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'hFF, 2'b01, 8'h80, 1'b1, 1'b0});
`ifdef CALC_MUL_EN
    vecs.push_back('{8'hF4, 8'h0B, 2'b11, 8'h7C, 1'b1, 1'b0});
    vecs.push_back('{8'h03, 8'hFC, 2'b11, 8'hF4, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'hFF, 2'b11, 8'h80, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 2'b11, 8'h80, 1'b0, 1'b0});
`else
    vecs.push_back('{8'hF4, 8'h0B, 2'b11, 8'h00, 1'b0, 1'b1});
`endif

    cycles(3);
    check("rst_phase", phase, 2'b00);
    check("rst_x", x, 8'h00);
    check("rst_flags", {ovf, err, busy}, 3'b000);
    rst_n = 1'b1;
    sw = 8'h5A;
    cycles(2);
    check("echo_a", x, 8'h5A);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Key held for 1000 cycles: a single press, only S_A -> S_B
    sw = 8'h11;
    key_n = 1'b0;
    changes = 0;
    prev_ph = phase;
    repeat (1000) begin
      @(negedge clk);
      if (phase != prev_ph) changes++;
      prev_ph = phase;
    end
    check("hold_changes", changes, 1);
    check("hold_phase", phase, 2'b01);
    key_n = 1'b1;
    cycles(6);
    sw = 8'h22;
    op = 2'b00;
    press_key();
    wait_done();
    check("hold_result", x, 8'h33);
    press_key();

    // Three clean pulses: S_A -> S_B -> EXEC -> DONE -> S_A
    sw = 8'h01;
    changes = 0;
    prev_ph = phase;
    repeat (3) begin
      key_n = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (phase != prev_ph) changes++;
        prev_ph = phase;
      end
      key_n = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (phase != prev_ph) changes++;
        prev_ph = phase;
      end
    end
    check("bounce_changes", changes, 4);
    check("bounce_phase", phase, 2'b00);

    // Reset while in S_B
    sw = 8'h44;
    press_key();
    cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check("rstB_phase", phase, 2'b00);
    check("rstB_out", {x, ovf, err, busy}, 11'h000);
    @(negedge clk) rst_n = 1'b1;
    cycles(20);
    check("rstB_nopress", phase, 2'b00);

`ifdef CALC_MUL_EN
    // Multiply: busy spans S_EXEC plus WIDTH multiplier cycles; a press inside is dropped
    sw = 8'hF4;
    press_key();
    sw = 8'h0B;
    op = 2'b11;
    key_n = 1'b0;
    nb = 0;
    while (!busy && nb < 20) begin
      @(negedge clk);
      nb++;
    end
    nb = 0;
    while (busy && nb < 40) begin
      if (nb == 1) key_n = 1'b1;
      if (nb == 3) key_n = 1'b0;
      if (nb == 6) key_n = 1'b1;
      @(negedge clk);
      nb++;
    end
    key_n = 1'b1;
    check("mul_busy_cycles", nb, 9);
    check("mul_x", x, 8'h7C);
    check("mul_ovf", ovf, 1'b1);
    cycles(15);
    check("mul_drop_phase", phase, 2'b11);
    press_key();
    check("mul_ret_phase", phase, 2'b00);

    // Reset in the middle of the multiplier
    sw = 8'hF4;
    press_key();
    sw = 8'h0B;
    op = 2'b11;
    key_n = 1'b0;
    nb = 0;
    while (!busy && nb < 20) begin
      @(negedge clk);
      nb++;
    end
    key_n = 1'b1;
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    check("rstM_phase", phase, 2'b00);
    check("rstM_out", {x, ovf, err, busy}, 11'h000);
    @(negedge clk) rst_n = 1'b1;
    cycles(20);
    check("rstM_nopress", phase, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
